btn_ctrl: RTL and testbench



---
 rtl/btn_ctrl.sv | 114 +++++++++++
 tb/tb_btn_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_ctrl.sv
// Push-button conditioner: per-button 2-FF synchronizer and debounce, press pulses,
// and the latched mode / one-hot colour selections consumed by the LED demo top.
module btn_ctrl #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clock,
  input  logic             i_ck_reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_press,
  output logic             o_mode,
  output logic [2:0]       o_color_sel
);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       COLOR_RST = 3'b001;

  logic [N_BTN-1:0]            sync1_q;
  logic [N_BTN-1:0]            sync2_q;
  logic [N_BTN-1:0]            lvl_q;
  logic [N_BTN-1:0]            lvl_d;
  logic [N_BTN-1:0]            lvl_dly_q;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_d;
  logic                        mode_q;
  logic                        mode_d;
  logic [2:0]                  color_q;
  logic [2:0]                  color_d;
  logic [N_BTN-1:0]            press_s;

  // The highest-index colour button wins when several pulse together.
  function automatic logic [2:0] color_next(input logic [2:0] press, input logic [2:0] cur);
    logic [2:0] res;
    if (press[2]) begin
      res = 3'b100;
    end else if (press[1]) begin
      res = 3'b010;
    end else if (press[0]) begin
      res = 3'b001;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  always_ff @(posedge clock or posedge i_ck_reset) begin
    if (i_ck_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = '0;
        lvl_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge i_ck_reset) begin
    if (i_ck_reset) begin
      cnt_q     <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
    end
  end

  assign press_s = lvl_q & ~lvl_dly_q;

  always_comb begin
    mode_d  = mode_q;
    color_d = color_next(press_s[3:1], color_q);
    if (press_s[0]) begin
      mode_d = ~mode_q;
    end else begin
      mode_d = mode_q;
    end
  end

  always_ff @(posedge clock or posedge i_ck_reset) begin
    if (i_ck_reset) begin
      mode_q  <= 1'b0;
      color_q <= COLOR_RST;
    end else begin
      mode_q  <= mode_d;
      color_q <= color_d;
    end
  end

  assign o_btn_level = lvl_q;
  assign o_btn_press = press_s;
  assign o_mode      = mode_q;
  assign o_color_sel = color_q;

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with DEBOUNCE_CYCLES=4: inputs change just after a falling
// edge, outputs are sampled on falling edges; k counts rising edges since the stimulus change.
module tb_btn_ctrl;

  logic       clock;
  logic       i_ck_reset;
  logic [3:0] i_btn;
  logic [3:0] o_btn_level;
  logic [3:0] o_btn_press;
  logic       o_mode;
  logic [2:0] o_color_sel;

  int checks = 0;
  int errors = 0;

  btn_ctrl #(.N_BTN(4), .DEBOUNCE_CYCLES(4)) dut (
    .clock      (clock),
    .i_ck_reset (i_ck_reset),
    .i_btn      (i_btn),
    .o_btn_level(o_btn_level),
    .o_btn_press(o_btn_press),
    .o_mode     (o_mode),
    .o_color_sel(o_color_sel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset(input logic [3:0] btn);
    i_ck_reset = 1'b1;
    i_btn      = btn;
    repeat (3) @(negedge clock);
    i_ck_reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_press;
    logic [3:0] exp_level;
    i_btn = 4'b1111;
    #1 i_ck_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (o_btn_level !== 4'b0000 || o_btn_press !== 4'b0000 || o_mode !== 1'b0 || o_color_sel !== 3'b001) begin
        errors++;
        $display("FAIL reset_hold: level=%b press=%b mode=%b color=%b want 0000 0000 0 001",
                 o_btn_level, o_btn_press, o_mode, o_color_sel);
      end
    end
    i_ck_reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      exp_level = (k >= 6) ? 4'b1111 : 4'b0000;
      exp_press = (k == 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (o_btn_level !== exp_level || o_btn_press !== exp_press) begin
        errors++;
        $display("FAIL reset_reaccept k=%0d: level=%b press=%b want %b %b",
                 k, o_btn_level, o_btn_press, exp_level, exp_press);
      end
    end
    checks++;
    if (o_mode !== 1'b1 || o_color_sel !== 3'b100) begin
      errors++;
      $display("FAIL reset_select: mode=%b color=%b want 1 100", o_mode, o_color_sel);
    end
  endtask

  task automatic test_mode_press();
    int pulses;
    apply_reset(4'b0000);
    i_btn = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      checks++;
      if (o_btn_press !== ((k == 6) ? 4'b0001 : 4'b0000) || o_mode !== (k >= 7)) begin
        errors++;
        $display("FAIL mode_press k=%0d: press=%b mode=%b want press %b mode %b",
                 k, o_btn_press, o_mode, (k == 6) ? 4'b0001 : 4'b0000, (k >= 7));
      end
    end
    i_btn  = 4'b0000;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (o_btn_press !== 4'b0000) pulses++;
    end
    checks++;
    if (pulses !== 0 || o_mode !== 1'b1 || o_btn_level !== 4'b0000) begin
      errors++;
      $display("FAIL mode_release: pulses=%0d mode=%b level=%b want 0 1 0000", pulses, o_mode, o_btn_level);
    end
    i_btn  = 4'b0001;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (o_btn_press[0] === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1 || o_mode !== 1'b0) begin
      errors++;
      $display("FAIL mode_second: pulses=%0d mode=%b want 1 0", pulses, o_mode);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    logic [3:0] exp_press;
    int pulses;
    pat = 8'b00110111;
    apply_reset(4'b0000);
    for (int k = 1; k <= 20; k++) begin
      i_btn = (k <= 8) ? {1'b0, pat[k-1], 2'b00} : 4'b0100;
      @(negedge clock);
      exp_press = (k == 14) ? 4'b0100 : 4'b0000;
      checks++;
      if (o_btn_press !== exp_press) begin
        errors++;
        $display("FAIL bounce_press k=%0d: press=%b want %b", k, o_btn_press, exp_press);
      end
    end
    checks++;
    if (o_color_sel !== 3'b010 || o_btn_level !== 4'b0100) begin
      errors++;
      $display("FAIL bounce_select: color=%b level=%b want 010 0100", o_color_sel, o_btn_level);
    end
    i_btn = 4'b0000;
    repeat (10) @(negedge clock);
    pulses = 0;
    for (int k = 1; k <= 15; k++) begin
      i_btn = (k <= 3) ? 4'b0100 : 4'b0000;
      @(negedge clock);
      if (o_btn_press !== 4'b0000 || o_btn_level !== 4'b0000) pulses++;
    end
    checks++;
    if (pulses !== 0 || o_color_sel !== 3'b010) begin
      errors++;
      $display("FAIL short_glitch: bad_cycles=%0d color=%b want 0 010", pulses, o_color_sel);
    end
  endtask

  task automatic test_two_colors();
    logic [3:0] exp_press;
    apply_reset(4'b0000);
    i_btn = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      exp_press = (k == 6) ? 4'b1010 : 4'b0000;
      checks++;
      if (o_btn_press !== exp_press) begin
        errors++;
        $display("FAIL two_colors_press k=%0d: press=%b want %b", k, o_btn_press, exp_press);
      end
    end
    checks++;
    if (o_color_sel !== 3'b100 || o_mode !== 1'b0) begin
      errors++;
      $display("FAIL two_colors_select: color=%b mode=%b want 100 0", o_color_sel, o_mode);
    end
  endtask

  task automatic test_back_to_back();
    i_btn = 4'b0000;
    repeat (10) @(negedge clock);
    i_btn = 4'b0011;
    repeat (6) @(negedge clock);
    checks++;
    if (o_btn_press !== 4'b0011 || o_mode !== 1'b0 || o_color_sel !== 3'b100) begin
      errors++;
      $display("FAIL combo_before: press=%b mode=%b color=%b want 0011 0 100", o_btn_press, o_mode, o_color_sel);
    end
    @(negedge clock);
    checks++;
    if (o_btn_press !== 4'b0000 || o_mode !== 1'b1 || o_color_sel !== 3'b001) begin
      errors++;
      $display("FAIL combo_after: press=%b mode=%b color=%b want 0000 1 001", o_btn_press, o_mode, o_color_sel);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    apply_reset(4'b1000);
    repeat (8) @(negedge clock);
    i_btn = 4'b0000;
    repeat (10) @(negedge clock);
    checks++;
    if (o_color_sel !== 3'b100) begin
      errors++;
      $display("FAIL mid_setup: color=%b want 100", o_color_sel);
    end
    i_btn = 4'b0100;
    repeat (4) @(negedge clock);
    checks++;
    if (dut.cnt_q[2] !== 2'd2) begin
      errors++;
      $display("FAIL mid_count: cnt=%0d want 2", dut.cnt_q[2]);
    end
    #2 i_ck_reset = 1'b1;
    #1;
    checks++;
    if (dut.cnt_q[2] !== 2'd0 || o_btn_level !== 4'b0000 || o_color_sel !== 3'b001) begin
      errors++;
      $display("FAIL mid_async: cnt=%0d level=%b color=%b want 0 0000 001", dut.cnt_q[2], o_btn_level, o_color_sel);
    end
    repeat (2) @(negedge clock);
    i_ck_reset = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (o_btn_press === 4'b0100) begin
        pulses++;
        checks++;
        if (k !== 6) begin
          errors++;
          $display("FAIL mid_latency: pulse at k=%0d want 6", k);
        end
      end
    end
    checks++;
    if (pulses !== 1 || o_color_sel !== 3'b010) begin
      errors++;
      $display("FAIL mid_reaccept: pulses=%0d color=%b want 1 010", pulses, o_color_sel);
    end
  endtask

  initial begin
    i_ck_reset = 1'b0;
    i_btn      = 4'b0000;
    test_reset();
    test_mode_press();
    test_bounce();
    test_two_colors();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
